// File: rtl/gate_truth_table_checker.sv
// Sweeps every input vector of an external combinational gate, samples its output
// after a settle delay and scores it against the gate function selected by mode.
module gate_truth_table_checker #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        mode,
  output logic [N_IN-1:0]   stim,
  input  logic              dut_y,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [N_IN-1:0]   first_err_vec,
  output logic              first_err_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam int unsigned WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t              r_state;
  logic [2:0]          r_mode;
  logic [N_IN-1:0]     r_vec;
  logic [N_IN-1:0]     r_stim;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [ERR_W-1:0]    r_err;
  logic [N_IN-1:0]     r_first_vec;
  logic                r_first_valid;

  logic                w_expect;
  logic                w_mode_ok;
  logic                w_mismatch;
  logic                w_last;
  logic [ERR_W-1:0]    w_err_next;

  always_comb begin
    w_expect = 1'b0;
    case (r_mode)
      3'b000:  w_expect = &r_stim;
      3'b001:  w_expect = |r_stim;
      3'b010:  w_expect = ^r_stim;
      3'b011:  w_expect = ~&r_stim;
      3'b100:  w_expect = ~|r_stim;
      3'b101:  w_expect = ~^r_stim;
      default: w_expect = 1'b0;
    endcase
  end

  assign w_mode_ok  = (r_mode[2:1] != 2'b11);
  assign w_mismatch = (dut_y != w_expect);
  assign w_last     = (r_vec == '1);
  // Counter saturates at all-ones; the final sample feeds pass on the same edge.
  assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mode        <= '0;
      r_vec         <= '0;
      r_stim        <= '0;
      r_wait        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err         <= '0;
      r_first_vec   <= '0;
      r_first_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_mode        <= mode;
            r_err         <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_busy        <= 1'b1;
            r_vec         <= '0;
            r_stim        <= '0;
            r_wait        <= '0;
            r_state       <= DRIVE;
          end
        end
        DRIVE: begin
          if (!w_mode_ok) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
            r_state <= DONE;
          end else if (r_wait == WAIT_W'(SETTLE - 1)) begin
            r_wait  <= '0;
            r_state <= SAMPLE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        SAMPLE: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_first_valid) begin
            r_first_vec   <= r_vec;
            r_first_valid <= 1'b1;
          end
          if (w_last) begin
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
            r_state <= DONE;
          end else begin
            r_vec   <= r_vec + N_IN'(1);
            r_stim  <= r_vec + N_IN'(1);
            r_state <= DRIVE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stim            = r_stim;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err;
  assign first_err_vec   = r_first_vec;
  assign first_err_valid = r_first_valid;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: three configurations driven by
// behavioural gate models that can be ideal or stuck at a constant.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // A: N_IN=2 SETTLE=1 ERR_W=8; B: N_IN=3 SETTLE=2 ERR_W=8; C: N_IN=3 SETTLE=1 ERR_W=2
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [2:0] mode_a = '0, mode_b = '0, mode_c = '0;
  int         fault_a = 0, fault_b = 0, fault_c = 0;  // 0 ideal, 1 stuck-0, 2 stuck-1
  logic [1:0] stim_a, fev_a;
  logic [2:0] stim_b, fev_b, stim_c, fev_c;
  logic [7:0] err_a, err_b;
  logic [1:0] err_c;
  logic       y_a, y_b, y_c;
  logic       busy_a, done_a, pass_a, fv_a;
  logic       busy_b, done_b, pass_b, fv_b;
  logic       busy_c, done_c, pass_c, fv_c;

  function automatic logic ideal_gate(input logic [2:0] m, input logic [7:0] v,
                                      input int unsigned n);
    logic a, o, x, r;
    a = 1'b1; o = 1'b0; x = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      a = a & v[i]; o = o | v[i]; x = x ^ v[i];
    end
    case (m)
      3'd0: r = a;
      3'd1: r = o;
      3'd2: r = x;
      3'd3: r = ~a;
      3'd4: r = ~o;
      3'd5: r = ~x;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic gate_model(input int f, input logic [2:0] m,
                                      input logic [7:0] v, input int unsigned n);
    if (f == 1) return 1'b0;
    if (f == 2) return 1'b1;
    return ideal_gate(m, v, n);
  endfunction

  always_comb y_a = gate_model(fault_a, mode_a, 8'(stim_a), 2);
  always_comb y_b = gate_model(fault_b, mode_b, 8'(stim_b), 3);
  always_comb y_c = gate_model(fault_c, mode_c, 8'(stim_c), 3);

  gate_truth_table_checker #(.N_IN(2), .SETTLE(1), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .stim(stim_a),
    .dut_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_vec(fev_a), .first_err_valid(fv_a));

  gate_truth_table_checker #(.N_IN(3), .SETTLE(2), .ERR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .stim(stim_b),
    .dut_y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_vec(fev_b), .first_err_valid(fv_b));

  gate_truth_table_checker #(.N_IN(3), .SETTLE(1), .ERR_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .mode(mode_c), .stim(stim_c),
    .dut_y(y_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_err_vec(fev_c), .first_err_valid(fv_c));

  // Returns at the falling edge after E0, the rising edge that accepts start.
  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) start_a = 1'b1; else if (which == 1) start_b = 1'b1; else start_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy_a, done_a, pass_a, fv_a, stim_a, err_a, fev_a} !== '0) begin
      tests_failed++;
      $display("FAIL reset_in: got busy%b done%b pass%b fv%b stim%b err%0d fev%b want all 0",
               busy_a, done_a, pass_a, fv_a, stim_a, err_a, fev_a);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy_a, done_a, pass_a, fv_a, stim_a, err_a, busy_b, stim_b, busy_c, stim_c} !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy_a%b done_a%b stim_a%b busy_b%b busy_c%b want all 0",
               busy_a, done_a, stim_a, busy_b, busy_c);
    end
  endtask

  task automatic test_or_ideal;
    mode_a = 3'b001; fault_a = 0;
    pulse_start(0);
    for (int j = 0; j < 8; j++) begin
      tests_run++;
      if (stim_a !== 2'(j / 2) || done_a !== 1'b0 || busy_a !== 1'b1) begin
        tests_failed++;
        $display("FAIL or_seq[%0d]: got stim%b done%b busy%b want stim%b done0 busy1",
                 j, stim_a, done_a, busy_a, 2'(j / 2));
      end
      @(negedge clk);
    end
    tests_run++;
    if ({done_a, busy_a, pass_a, err_a, fv_a, stim_a} !== {1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 2'b00}) begin
      tests_failed++;
      $display("FAIL or_done: got done%b busy%b pass%b err%0d fv%b stim%b want 1 0 1 0 0 00",
               done_a, busy_a, pass_a, err_a, fv_a, stim_a);
    end
  endtask

  task automatic test_stuck0;
    mode_a = 3'b001; fault_a = 1;
    pulse_start(0);
    tests_run++;
    if (done_a !== 1'b0 || pass_a !== 1'b0 || busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL stuck0_restart: got done%b pass%b busy%b want 0 0 1", done_a, pass_a, busy_a);
    end
    repeat (7) @(negedge clk);
    tests_run++;
    if (done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL stuck0_early: got done%b want 0", done_a);
    end
    @(negedge clk);
    tests_run++;
    if ({done_a, pass_a, err_a, fev_a, fv_a} !== {1'b1, 1'b0, 8'd3, 2'b01, 1'b1}) begin
      tests_failed++;
      $display("FAIL stuck0_result: got done%b pass%b err%0d fev%b fv%b want 1 0 3 01 1",
               done_a, pass_a, err_a, fev_a, fv_a);
    end
  endtask

  task automatic test_reserved;
    mode_a = 3'b110; fault_a = 0;
    pulse_start(0);
    tests_run++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsv_accept: got busy%b done%b want 1 0", busy_a, done_a);
    end
    @(negedge clk);
    tests_run++;
    if ({done_a, busy_a, pass_a, err_a, fv_a, stim_a} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'b00}) begin
      tests_failed++;
      $display("FAIL rsv_done: got done%b busy%b pass%b err%0d fv%b stim%b want 1 0 0 0 0 00",
               done_a, busy_a, pass_a, err_a, fv_a, stim_a);
    end
  endtask

  task automatic test_back_to_back;
    mode_b = 3'b101; fault_b = 0;
    pulse_start(1);
    for (int j = 0; j < 24; j++) begin
      if (j == 4) start_b = 1'b1;
      if (j == 5) start_b = 1'b0;
      tests_run++;
      if (stim_b !== 3'(j / 3) || done_b !== 1'b0) begin
        tests_failed++;
        $display("FAIL xnor_seq[%0d]: got stim%b done%b want stim%b done0",
                 j, stim_b, done_b, 3'(j / 3));
      end
      @(negedge clk);
    end
    tests_run++;
    if ({done_b, busy_b, pass_b, err_b, fv_b, stim_b} !== {1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 3'b000}) begin
      tests_failed++;
      $display("FAIL xnor_done: got done%b busy%b pass%b err%0d fv%b stim%b want 1 0 1 0 0 000",
               done_b, busy_b, pass_b, err_b, fv_b, stim_b);
    end
  endtask

  task automatic test_saturate;
    mode_c = 3'b000; fault_c = 2;
    pulse_start(2);
    repeat (15) @(negedge clk);
    tests_run++;
    if (done_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_early: got done%b want 0", done_c);
    end
    @(negedge clk);
    tests_run++;
    if ({done_c, pass_c, err_c, fev_c, fv_c} !== {1'b1, 1'b0, 2'b11, 3'b000, 1'b1}) begin
      tests_failed++;
      $display("FAIL sat_result: got done%b pass%b err%0d fev%b fv%b want 1 0 3 000 1",
               done_c, pass_c, err_c, fev_c, fv_c);
    end
  endtask

  task automatic test_reset_mid;
    mode_a = 3'b001; fault_a = 1;
    pulse_start(0);
    repeat (4) @(negedge clk);
    tests_run++;
    if (stim_a !== 2'b10 || err_a !== 8'd1 || fv_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pre: got stim%b err%0d fv%b want 10 1 1", stim_a, err_a, fv_a);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy_a, done_a, pass_a, fv_a, stim_a, err_a, fev_a} !== '0) begin
      tests_failed++;
      $display("FAIL mid_async: got busy%b done%b pass%b fv%b stim%b err%0d fev%b want all 0",
               busy_a, done_a, pass_a, fv_a, stim_a, err_a, fev_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fault_a = 0;
    @(negedge clk);
    pulse_start(0);
    repeat (7) @(negedge clk);
    tests_run++;
    if (done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_early: got done%b want 0", done_a);
    end
    @(negedge clk);
    tests_run++;
    if ({done_a, pass_a, err_a, fv_a} !== {1'b1, 1'b1, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_clean: got done%b pass%b err%0d fv%b want 1 1 0 0",
               done_a, pass_a, err_a, fv_a);
    end
  endtask

  initial begin
    test_reset;
    test_or_ideal;
    test_stuck0;
    test_reserved;
    test_back_to_back;
    test_saturate;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
